// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole receive side: judge states,
// mole count and BCD limits.
package whack_pkg;

   localparam int NUM_MOLES = 3;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_LOCKED
   } judge_state_t;

endpackage

// File: rtl/mole_hit_judge_if.sv
// Bundle between the player/display side and the hit judge: game enable,
// buttons and mole lines in, hit/miss pulses and BCD score digits out.
interface mole_hit_judge_if;
   import whack_pkg::*;

   logic                 game;
   logic [NUM_MOLES-1:0] button;
   logic [NUM_MOLES-1:0] mole;
   logic                 hit;
   logic                 miss;
   logic [3:0]           score_ones;
   logic [3:0]           score_tens;

   modport master (output game, button, mole,
                   input  hit, miss, score_ones, score_tens);
   modport slave  (input  game, button, mole,
                   output hit, miss, score_ones, score_tens);
endinterface

// File: rtl/button_debounce.sv
// One raw button: two-flop synchroniser, stable-level debounce counter and a
// one-cycle pulse on each accepted press (release produces nothing).
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clock,
   input  logic resetn,
   input  logic raw,
   output logic press
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             level;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_a  <= 1'b0;
         sync_b  <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync_a  <= raw;
         sync_b  <= sync_a;
         level_q <= level;
         press   <= level & ~level_q;
         // Any sample agreeing with the current level restarts the count.
         if (sync_b != level) begin
            if (cnt == CNT_LAST) begin
               level <= ~level;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/mole_hit_judge.sv
// Judges debounced button presses against the mole lines, pulses hit/miss
// and keeps a saturating two-digit BCD score.
//
//   state     | meaning
//   ST_IDLE   | game off, score held at 00, presses ignored
//   ST_ARMED  | waiting for a press against the current mole
//   ST_LOCKED | mole already scored, wait for mole lines to clear
module mole_hit_judge
   import whack_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 20
) (
   input  logic             clock,
   input  logic             resetn,
   mole_hit_judge_if.slave  bus
);
   logic [NUM_MOLES-1:0] press;
   judge_state_t         state;
   logic                 hit_r;
   logic                 miss_r;
   logic [3:0]           ones;
   logic [3:0]           tens;
   logic                 pressed_any;
   logic                 wrong;
   logic                 mole_up;

   for (genvar i = 0; i < NUM_MOLES; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_debounce (
         .clock (clock),
         .resetn(resetn),
         .raw   (bus.button[i]),
         .press (press[i])
      );
   end

   assign pressed_any = |press;
   assign wrong       = |(press & ~bus.mole);
   assign mole_up     = |bus.mole;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         hit_r  <= 1'b0;
         miss_r <= 1'b0;
         ones   <= 4'd0;
         tens   <= 4'd0;
      end else begin
         hit_r  <= 1'b0;
         miss_r <= 1'b0;
         if (!bus.game) begin
            state <= ST_IDLE;
            ones  <= 4'd0;
            tens  <= 4'd0;
         end else begin
            case (state)
               ST_IDLE: state <= ST_ARMED;
               ST_ARMED: begin
                  if (mole_up && pressed_any) begin
                     if (wrong) begin
                        miss_r <= 1'b1;
                        if (ones == 4'd0) begin
                           if (tens != 4'd0) begin
                              ones <= BCD_MAX;
                              tens <= tens - 4'd1;
                           end
                        end else begin
                           ones <= ones - 4'd1;
                        end
                     end else begin
                        hit_r <= 1'b1;
                        state <= ST_LOCKED;
                        if (ones == BCD_MAX) begin
                           if (tens != BCD_MAX) begin
                              ones <= 4'd0;
                              tens <= tens + 4'd1;
                           end
                        end else begin
                           ones <= ones + 4'd1;
                        end
                     end
                  end
               end
               ST_LOCKED: if (!mole_up) state <= ST_ARMED;
               default:   state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.hit        = hit_r;
   assign bus.miss       = miss_r;
   assign bus.score_ones = ones;
   assign bus.score_tens = tens;
endmodule

// File: tb/tb_mole_hit_judge.sv
// Directed plus randomized checks of mole_hit_judge against a score/lock
// model kept as plain integers.
module tb_mole_hit_judge;
   import whack_pkg::*;

   localparam int D = 4;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   int   tests  = 0;
   int   fails  = 0;
   int   hits_seen;
   int   miss_seen;
   int   m_score;
   bit   m_locked;

   always #5 clock = ~clock;

   mole_hit_judge_if bus ();

   mole_hit_judge #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      check("hit_miss_exclusive", 32'(bus.hit & bus.miss), 0);
      if (bus.hit)  hits_seen++;
      if (bus.miss) miss_seen++;
   endtask

   task automatic check_score(input string tag);
      check({tag, "_ones"}, 32'(bus.score_ones), 32'(m_score % 10));
      check({tag, "_tens"}, 32'(bus.score_tens), 32'(m_score / 10));
   endtask

   task automatic unlock();
      bus.mole = 3'b000;
      repeat (3) step();
      m_locked = 1'b0;
   endtask

   task automatic game_cycle();
      bus.game = 1'b0;
      repeat (3) step();
      bus.game = 1'b1;
      step();
      m_score  = 0;
      m_locked = 1'b0;
      check_score("game_cycle");
   endtask

   task automatic press_txn(input logic [2:0] mole_v, input logic [2:0] btn, input string tag);
      int exp_hit;
      int exp_miss;
      exp_hit  = 0;
      exp_miss = 0;
      if (mole_v == 3'b000) begin
         m_locked = 1'b0;
      end else if (!m_locked) begin
         if ((btn & ~mole_v) != 3'b000) begin
            exp_miss = 1;
            m_score  = (m_score > 0) ? m_score - 1 : 0;
         end else begin
            exp_hit  = 1;
            m_score  = (m_score < 99) ? m_score + 1 : 99;
            m_locked = 1'b1;
         end
      end
      bus.mole   = mole_v;
      bus.button = btn;
      hits_seen  = 0;
      miss_seen  = 0;
      repeat (D + 8) step();
      check({tag, "_hits"}, 32'(hits_seen), 32'(exp_hit));
      check({tag, "_misses"}, 32'(miss_seen), 32'(exp_miss));
      check_score(tag);
      bus.button = 3'b000;
      hits_seen  = 0;
      miss_seen  = 0;
      repeat (D + 6) step();
      check({tag, "_release_pulses"}, 32'(hits_seen + miss_seen), 0);
   endtask

   task automatic set_score(input int target);
      for (int g = 0; g < 300 && m_score != target; g++) begin
         unlock();
         if (m_score < target) press_txn(3'b001, 3'b001, "climb");
         else                  press_txn(3'b100, 3'b001, "descend");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] mv;
      logic [2:0] bv;
      int         r;
      int         idx;

      bus.game   = 1'b0;
      bus.button = 3'b000;
      bus.mole   = 3'b000;
      m_score    = 0;
      m_locked   = 1'b0;
      hits_seen  = 0;
      miss_seen  = 0;

      // Reset state
      repeat (2) step();
      check("rst_hit", 32'(bus.hit), 0);
      check("rst_miss", 32'(bus.miss), 0);
      check_score("rst");
      resetn   = 1'b1;
      bus.game = 1'b1;
      repeat (2) step();

      // Reset then start: clean press of button[1] on mole 2
      press_txn(3'b010, 3'b010, "start_hit");

      // Exact latency: button rises just after edge 0, hit visible after edge D+4
      unlock();
      bus.mole   = 3'b001;
      bus.button = 3'b001;
      hits_seen  = 0;
      repeat (D + 3) step();
      check("lat_early", 32'(hits_seen), 0);
      step();
      m_score++;
      m_locked = 1'b1;
      check("lat_hit", 32'(bus.hit), 1);
      check_score("lat");
      step();
      check("lat_one_cycle", 32'(bus.hit), 0);
      bus.button = 3'b000;
      repeat (D + 6) step();

      // Bounce filtering: toggle every 2 cycles for 20 cycles, then hold
      unlock();
      bus.mole  = 3'b001;
      hits_seen = 0;
      miss_seen = 0;
      for (int i = 0; i < 10; i++) begin
         bus.button[0] = ~bus.button[0];
         repeat (2) step();
      end
      check("bounce_quiet", 32'(hits_seen + miss_seen), 0);
      bus.button[0] = 1'b1;
      repeat (D + 8) step();
      m_score++;
      m_locked = 1'b1;
      check("bounce_hits", 32'(hits_seen), 1);
      check("bounce_misses", 32'(miss_seen), 0);
      check_score("bounce");
      bus.button = 3'b000;
      repeat (D + 6) step();

      // Wrong button at 05 and at 00
      set_score(5);
      unlock();
      press_txn(3'b100, 3'b001, "wrong_at_5");
      set_score(0);
      unlock();
      press_txn(3'b100, 3'b001, "wrong_at_0");

      // Presses with no mole are ignored
      press_txn(3'b000, 3'b011, "no_mole");

      // BCD carry, saturation, borrow
      set_score(9);
      unlock();
      press_txn(3'b001, 3'b001, "carry_9_10");
      set_score(99);
      unlock();
      press_txn(3'b001, 3'b001, "sat_99");
      set_score(10);
      unlock();
      press_txn(3'b100, 3'b001, "borrow_10_9");

      // Correct and wrong together count as a miss
      unlock();
      press_txn(3'b010, 3'b011, "mixed_press");

      // LOCKED: no double count until mole clears
      unlock();
      press_txn(3'b010, 3'b010, "lock_first");
      press_txn(3'b010, 3'b010, "lock_repeat");
      press_txn(3'b010, 3'b100, "lock_wrong");
      unlock();
      press_txn(3'b010, 3'b010, "lock_rearmed");

      // Game off on the same edge the press is judged
      unlock();
      bus.mole   = 3'b001;
      bus.button = 3'b001;
      hits_seen  = 0;
      miss_seen  = 0;
      repeat (D + 3) step();
      bus.game = 1'b0;
      step();
      m_score  = 0;
      m_locked = 1'b0;
      check("gameoff_hit", 32'(bus.hit), 0);
      check_score("gameoff");
      repeat (3) step();
      bus.button = 3'b000;
      bus.game   = 1'b1;
      repeat (D + 6) step();
      check("gameoff_pulses", 32'(hits_seen + miss_seen), 0);
      check_score("gameoff_after");

      // Reset mid-debounce: no press after release
      set_score(3);
      unlock();
      bus.mole   = 3'b001;
      bus.button = 3'b001;
      repeat (2) step();
      resetn     = 1'b0;
      bus.button = 3'b000;
      hits_seen  = 0;
      miss_seen  = 0;
      repeat (2) step();
      m_score  = 0;
      m_locked = 1'b0;
      check_score("rst_mid");
      resetn = 1'b1;
      repeat (D + 8) step();
      check("rst_mid_pulses", 32'(hits_seen + miss_seen), 0);
      check_score("rst_mid_after");

      // Randomized phase
      for (int t = 0; t < 150; t++) begin
         r = $urandom_range(0, 9);
         if (r == 0) game_cycle();
         else if (r < 5) unlock();
         idx = $urandom_range(0, 3);
         mv  = (idx == 0) ? 3'b000 : 3'(1 << (idx - 1));
         if (mv != 3'b000 && $urandom_range(0, 1) == 1) bv = mv;
         else bv = 3'($urandom_range(1, 7));
         press_txn(mv, bv, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
